tpu_systolic_array: RTL and testbench

TPU_SYSTOLIC_ARRAY -- requirements
Module: tpu_systolic_array

---
 rtl/tpu_systolic_array.sv | 60 ++++++
 tb/tb_tpu_systolic_array.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tpu_systolic_array.sv
// tpu_systolic_array: 4x4 weight-stationary systolic array with signed MAC PEs.
module tpu_systolic_array #(
  parameter int bit_width = 16,
  parameter int acc_width = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      control,
  input  logic [4*bit_width-1:0]    data_arr,
  input  logic [4*bit_width-1:0]    wt_arr,
  output logic [4*acc_width-1:0]    acc_out,
  output logic [acc_width-1:0]      pe30_out,
  output logic [acc_width-1:0]      pe31_out,
  output logic [acc_width-1:0]      pe32_out,
  output logic [acc_width-1:0]      pe33_out
);
  logic signed [bit_width-1:0] w [4][4];
  logic signed [bit_width-1:0] x [4][4];
  logic        [acc_width-1:0] p [4][4];
  for (genvar i = 0; i < 4; i++) begin : g_row
    assign x[i][0] = data_arr[i*bit_width +: bit_width];
    for (genvar j = 0; j < 4; j++) begin : g_col
      logic signed [bit_width-1:0] w_in, w_r;
      logic        [acc_width-1:0] p_in, p_r;
      logic signed [acc_width-1:0] prod;
      if (i == 0) begin : g_top
        assign w_in = wt_arr[j*bit_width +: bit_width];
        assign p_in = '0;
      end else begin : g_top
        assign w_in = w[i-1][j];
        assign p_in = p[i-1][j];
      end
      // Operands sign-extend before multiply, so the product wraps like a 32-bit result widened.
      assign prod = acc_width'(x[i][j]) * acc_width'(w_r);
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          w_r <= '0;
          p_r <= '0;
        end else begin
          w_r <= control ? w_in : w_r;
          p_r <= control ? '0 : p_in + prod;
        end
      assign w[i][j] = w_r;
      assign p[i][j] = p_r;
      // The last column's data register would feed nothing, so it is not built.
      if (j < 3) begin : g_d
        logic signed [bit_width-1:0] d_r;
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) d_r <= '0;
          else d_r <= x[i][j];
        assign x[i][j+1] = d_r;
      end
    end
  end
  assign pe30_out = p[3][0];
  assign pe31_out = p[3][1];
  assign pe32_out = p[3][2];
  assign pe33_out = p[3][3];
  assign acc_out  = {p[3][3], p[3][2], p[3][1], p[3][0]};
endmodule

// File: tb/tb_tpu_systolic_array.sv
// tb_tpu_systolic_array: random and directed checks against a sum-of-products reference model.
module tb_tpu_systolic_array;
  localparam int bw = 16;
  localparam int aw = 40;
  logic clk = 0, rst_n = 0, control = 0;
  logic [4*bw-1:0] data_arr = '0, wt_arr = '0;
  logic [4*aw-1:0] acc_out;
  logic [aw-1:0] pe30_out, pe31_out, pe32_out, pe33_out;
  int errors = 0, checks = 0;
  logic [4*bw-1:0] hist [2048];
  bit ctrl_h [2048];
  logic [4*aw-1:0] out_log [2048];
  int e = 0;
  int k;
  shortint wm [4][4];
  logic [63:0] vv [2];

  always #5 clk = ~clk;

  tpu_systolic_array #(.bit_width(bw), .acc_width(aw)) dut (
    .clk(clk), .rst_n(rst_n), .control(control), .data_arr(data_arr), .wt_arr(wt_arr),
    .acc_out(acc_out), .pe30_out(pe30_out), .pe31_out(pe31_out), .pe32_out(pe32_out),
    .pe33_out(pe33_out)
  );

  task automatic check(input string tag, input logic [4*aw-1:0] got, input logic [4*aw-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint xs(int idx, int r);
    logic [4*bw-1:0] v;
    if (idx < 0) return 0;
    v = hist[idx];
    return longint'($signed(v[r*bw +: bw]));
  endfunction

  // Column j after edge t: row r sees the element that entered row r at edge t-3+r-j.
  function automatic logic [aw-1:0] model(int t, int j);
    longint s = 0;
    for (int r = 0; r < 4; r++) s += xs(t - 3 + r - j, r) * longint'(wm[r][j]);
    return s[aw-1:0];
  endfunction

  function automatic logic [aw-1:0] pe_at(int idx, int j);
    logic [4*aw-1:0] v;
    v = out_log[idx];
    return v[j*aw +: aw];
  endfunction

  task automatic step(input bit c, input logic [63:0] din, input logic [63:0] win);
    logic [4*aw-1:0] ex;
    bit valid;
    control = c;
    data_arr = din;
    wt_arr = win;
    @(posedge clk);
    hist[e] = din;
    ctrl_h[e] = c;
    if (c) begin
      for (int i = 3; i > 0; i--) for (int j = 0; j < 4; j++) wm[i][j] = wm[i-1][j];
      for (int j = 0; j < 4; j++) wm[0][j] = shortint'(win[j*bw +: bw]);
    end
    @(negedge clk);
    out_log[e] = {pe33_out, pe32_out, pe31_out, pe30_out};
    valid = 1;
    for (int q = 0; q < 4; q++) if (e - q >= 0 && ctrl_h[e-q]) valid = 0;
    ex = '0;
    for (int j = 0; j < 4; j++) ex[j*aw +: aw] = model(e, j);
    if (c) check("clear_on_load", acc_out, '0);
    else if (valid) begin
      check("model_acc", acc_out, ex);
      check("model_pe", {pe33_out, pe32_out, pe31_out, pe30_out}, ex);
    end
    e++;
  endtask

  task automatic load4(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    step(1, {$urandom, $urandom}, a);
    step(1, {$urandom, $urandom}, b);
    step(1, {$urandom, $urandom}, c);
    step(1, {$urandom, $urandom}, d);
  endtask

  task automatic feed(input int n, input logic [63:0] vecs [2], output int k0);
    logic [63:0] din;
    k0 = e;
    for (int c = 0; c < n + 6; c++) begin
      din = '0;
      for (int i = 0; i < 4; i++) if (c - i >= 0 && c - i < n) din[i*bw +: bw] = vecs[c-i][i*bw +: bw];
      step(0, din, '0);
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    #1;
    check("async_rst_acc", acc_out, '0);
    check("async_rst_pe", {pe33_out, pe32_out, pe31_out, pe30_out}, '0);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = 0;
    e = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wm[i][j] = 0;
    #3;
    check("reset_acc", acc_out, '0);
    check("reset_pe", {pe33_out, pe32_out, pe31_out, pe30_out}, '0);
    @(negedge clk);
    rst_n = 1;
    load4(64'h0001_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001);
    vv = '{64'h0004_0003_0002_0001, 64'h0};
    feed(1, vv, k);
    for (int j = 0; j < 4; j++) check($sformatf("ident_pe3%0d", j), pe_at(k + j + 3, j), aw'(j + 1));
    vv = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
    feed(2, vv, k);
    check("pipe_first", pe_at(k + 3, 0), 1);
    check("pipe_second", pe_at(k + 4, 0), 5);
    step(0, 64'h0004_0003_0002_0001, '0);
    for (int q = 0; q < 3; q++) step(0, '0, '0);
    check("pack_low", acc_out[aw-1:0], 1);
    check("pack_high", acc_out[4*aw-1:3*aw], 4);
    load4({4{16'hFFFF}}, {4{16'hFFFF}}, {4{16'hFFFF}}, {4{16'hFFFF}});
    vv = '{64'h0004_0003_0002_0001, 64'h0};
    feed(1, vv, k);
    for (int j = 0; j < 4; j++) check($sformatf("signed_pe3%0d", j), pe_at(k + j + 3, j), 40'hFF_FFFF_FFF6);
    for (int q = 0; q < 20; q++) step(0, {$urandom, $urandom}, {$urandom, $urandom});
    feed(1, vv, k);
    for (int j = 0; j < 4; j++) check($sformatf("hold_pe3%0d", j), pe_at(k + j + 3, j), 40'hFF_FFFF_FFF6);
    for (int q = 0; q < 4; q++) step(0, {$urandom, $urandom}, '0);
    step(1, {$urandom, $urandom}, {$urandom, $urandom});
    check("clear_one_edge", acc_out, '0);
    for (int r = 0; r < 3; r++) begin
      load4({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      for (int q = 0; q < 60; q++) begin
        step($urandom_range(0, 15) == 0, {$urandom, $urandom}, {$urandom, $urandom});
        if (r == 1 && q == 30) async_reset();
      end
    end
    step(1, '0, 64'h1111_2222_3333_4444);
    async_reset();
    for (int q = 0; q < 6; q++) step(0, {$urandom, $urandom}, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
